// File: rtl/shift_add_multiplier.sv
// Sequential 16x16 -> 32 shift-and-add multiplier. Every partial-product add goes through one 16-bit CLA.
// Optional macro SIGNED_MULT_EN adds the is_signed port and sign-magnitude signed support.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] r,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  // Four 4-bit lookahead groups; group boundary carries come from the second level below
  for (genvar i = 0; i < 4; i++) begin : grp
    localparam int B = 4 * i;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign gg[i]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[i]  = &p[B+3:B];
  end

  assign c[4]  = gg[0] | (gp[0] & c[0]);
  assign c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
  assign c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & c[0]);
  assign c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);

  assign r    = p ^ c[15:0];
  assign cout = c[16];

endmodule

module shift_add_multiplier (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
`ifdef SIGNED_MULT_EN
  input  logic        is_signed,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc;
  logic [4:0]  count;

  logic [15:0] load_a;
  logic [15:0] load_b;
  logic [31:0] final_value;
  logic [15:0] addend;
  logic [15:0] sum;
  logic        sum_cout;

`ifdef SIGNED_MULT_EN
  logic neg;
  logic load_neg;

  // Signed mode multiplies magnitudes; 0x8000 negates to itself, which reads as 32768 unsigned
  always_comb begin
    load_a   = (is_signed && a[15]) ? (~a + 16'd1) : a;
    load_b   = (is_signed && b[15]) ? (~b + 16'd1) : b;
    load_neg = is_signed & (a[15] ^ b[15]);
  end

  assign final_value = neg ? (~acc + 32'd1) : acc;
`else
  assign load_a      = a;
  assign load_b      = b;
  assign final_value = acc;
`endif

  assign addend = mplier[0] ? mcand : 16'd0;

  cla16 u_cla (
    .a    (acc[31:16]),
    .b    (addend),
    .cin  (1'b0),
    .r    (sum),
    .cout (sum_cout)
  );

  // Single FSM: operand latch on accept, one add-and-shift per RUN cycle, one-cycle result strobe
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      mcand   <= 16'd0;
      mplier  <= 16'd0;
      acc     <= 32'd0;
      count   <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 32'd0;
`ifdef SIGNED_MULT_EN
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            done    <= 1'b1;
            product <= final_value;
          end
          if (start) begin
            mcand  <= load_a;
            mplier <= load_b;
            acc    <= 32'd0;
            count  <= 5'd16;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SIGNED_MULT_EN
            neg    <= load_neg;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= {sum_cout, sum, acc[15:1]};
          mplier <= mplier >> 1;
          count  <= count - 5'd1;
          if (count == 5'd1) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed corner cases plus random operands against an arithmetic model.
// Define SIGNED_MULT_EN for both files to exercise the signed build.

module tb_shift_add_multiplier;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int total;
  int bad;
  logic [31:0] last_product;

  shift_add_multiplier dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SIGNED_MULT_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product straight from integer arithmetic
  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic sgn);
    longint sx;
    longint sy;
    longint res;
    sx = longint'(x);
    sy = longint'(y);
`ifdef SIGNED_MULT_EN
    if (sgn) begin
      if (x[15]) sx = sx - 65536;
      if (y[15]) sy = sy - 65536;
    end
`endif
    res = sx * sy;
    return res[31:0];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Waits up to a bounded number of edges for done; returns edges seen (edge of acceptance counts as 1)
  task automatic wait_done(input int start_edges, output int edges, output int busy_cycles, output bit seen);
    edges = start_edges;
    busy_cycles = 0;
    seen = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
      else busy_cycles += int'(busy);
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      n += int'(done);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y, input logic sgn, input string tag);
    logic [31:0] expected;
    int edges;
    int busy_cycles;
    bit seen;
    expected = model(x, y, sgn);
    @(negedge clk);
    a = x; b = y; is_signed = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
    check_output({tag, "_hold"}, product, last_product);
    wait_done(1, edges, busy_cycles, seen);
    busy_cycles += 1;
    check_output({tag, "_seen"}, 32'(seen), 32'd1);
    check_output({tag, "_latency"}, 32'(edges), 32'd18);
    check_output({tag, "_busy"}, 32'(busy_cycles), 32'd16);
    check_output({tag, "_product"}, product, expected);
    @(posedge clk); #1;
    check_output({tag, "_pulse"}, 32'(done), 32'd0);
    check_output({tag, "_held"}, product, expected);
    last_product = expected;
  endtask

  initial begin
    int edges;
    int busy_cycles;
    int n;
    bit seen;
    logic [15:0] rx;
    logic [15:0] ry;
    logic rs;

    total = 0;
    bad = 0;
    last_product = 32'd0;
    rstn = 1'b0; start = 1'b0; a = 16'd0; b = 16'd0; is_signed = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_product", product, 32'd0);
    @(negedge clk); rstn = 1'b1;

    apply_stimulus(16'h0003, 16'h0005, 1'b0, "mul3x5");
    apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0, "max_unsigned");
    apply_stimulus(16'h0000, 16'h1234, 1'b0, "zero");
    apply_stimulus(16'h1234, 16'h0001, 1'b0, "ident");
`ifdef SIGNED_MULT_EN
    apply_stimulus(16'hFFFF, 16'hFFFF, 1'b1, "s_m1xm1");
    apply_stimulus(16'h8000, 16'h0002, 1'b1, "s_min_x2");
    apply_stimulus(16'h8000, 16'h8000, 1'b1, "s_min_sq");
    apply_stimulus(16'h0007, 16'hFFFD, 1'b1, "s_pos_neg");
`endif

    // A second start while busy must be ignored
    @(negedge clk); a = 16'd2; b = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); a = 16'd7; b = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(6, edges, busy_cycles, seen);
    check_output("ignore_seen", 32'(seen), 32'd1);
    check_output("ignore_latency", 32'(edges), 32'd18);
    check_output("ignore_product", product, 32'h0000_0006);
    count_dones(25, n);
    check_output("ignore_single_done", 32'(n), 32'd0);
    last_product = 32'h0000_0006;

    // Reset in the middle of an operation aborts it
    @(negedge clk); a = 16'd9; b = 16'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_product", product, 32'd0);
    @(negedge clk); rstn = 1'b1;
    count_dones(25, n);
    check_output("abort_no_done", 32'(n), 32'd0);
    last_product = 32'd0;
    apply_stimulus(16'd4, 16'd4, 1'b0, "after_abort");

    // Reset wins over a simultaneous start
    @(negedge clk); rstn = 1'b0; start = 1'b1; a = 16'd5; b = 16'd5;
    @(posedge clk); #1;
    check_output("reset_over_start_busy", 32'(busy), 32'd0);
    @(negedge clk); start = 1'b0; rstn = 1'b1;
    count_dones(20, n);
    check_output("reset_over_start_no_done", 32'(n), 32'd0);
    last_product = 32'd0;

    // Start held high through DONE gives back-to-back operations
    @(negedge clk); a = 16'd1; b = 16'd1; start = 1'b1;
    @(posedge clk); #1; a = 16'd2; b = 16'd2;
    wait_done(1, edges, busy_cycles, seen);
    check_output("b2b_first_latency", 32'(edges), 32'd18);
    check_output("b2b_first_product", product, 32'h0000_0001);
    start = 1'b0;
    wait_done(0, edges, busy_cycles, seen);
    check_output("b2b_gap", 32'(edges), 32'd17);
    check_output("b2b_second_product", product, 32'h0000_0004);
    last_product = 32'h0000_0004;

    // Random operands against the model
    for (int i = 0; i < 16; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
`ifdef SIGNED_MULT_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      apply_stimulus(rx, ry, rs, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
